bcd_mod_counter: RTL and testbench

Parametrised two-digit BCD modulo counter. It generalises the seconds counter to any modulo from 2 to 100, e.g. 60 for seconds/minutes and 24 for hours.
Adds count enable, synchronous clear, validated parallel load (time-set), terminal-count flag and a registered carry pulse, so that instances cascade into a full watch datapath.
Wraps exactly at MODULO-1; the tens digit never passes the modulo boundary.

---
 rtl/bcd_mod_counter.sv | 120 ++++++++++++
 tb/tb_bcd_mod_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (0..MODULO-1) with clear, validated load, terminal count and carry.
// Optional down counting and the dir port are enabled by defining BCD_COUNTER_DOWN_COUNT_EN.
module bcd_mod_counter #(
  parameter int MODULO = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
`ifdef BCD_COUNTER_DOWN_COUNT_EN
  input  logic       dir,
`endif
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       term_cnt,
  output logic       carry,
  output logic       load_err
);

  generate
    if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
      $error("bcd_mod_counter: MODULO must be in 2..100");
    end
  endgenerate

  localparam logic [3:0] MAX_TENS = 4'((MODULO - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MODULO - 1) % 10);
  localparam logic [7:0] MOD_VAL  = 8'(MODULO);

  logic       dn;
  logic [7:0] value;
  logic [7:0] load_value;
  logic       at_max;
  logic       at_zero;
  logic       illegal;
  logic       load_ok;
  logic [3:0] tens_n;
  logic [3:0] ones_n;
  logic       carry_n;
  logic       load_err_n;

`ifdef BCD_COUNTER_DOWN_COUNT_EN
  assign dn = dir;
`else
  assign dn = 1'b0;
`endif

  assign value      = 8'(tens) * 8'd10 + 8'(ones);
  assign load_value = 8'(load_tens) * 8'd10 + 8'(load_ones);
  assign at_max     = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign at_zero    = (tens == 4'd0) && (ones == 4'd0);
  assign illegal    = (tens > 4'd9) || (ones > 4'd9) || (value >= MOD_VAL);
  assign load_ok    = (load_tens <= 4'd9) && (load_ones <= 4'd9) && (load_value < MOD_VAL);
  assign term_cnt   = dn ? at_zero : at_max;

  always_comb begin
    tens_n     = tens;
    ones_n     = ones;
    carry_n    = 1'b0;
    load_err_n = 1'b0;
    if (clr) begin
      tens_n = 4'd0;
      ones_n = 4'd0;
    end else if (load) begin
      if (load_ok) begin
        tens_n = load_tens;
        ones_n = load_ones;
      end else begin
        load_err_n = 1'b1;
      end
    end else if (tick) begin
      if (illegal) begin
        // Corrupted state recovers to 00 in either direction, flagged like a wrap
        tens_n  = 4'd0;
        ones_n  = 4'd0;
        carry_n = 1'b1;
      end else if (dn) begin
        if (at_zero) begin
          tens_n  = MAX_TENS;
          ones_n  = MAX_ONES;
          carry_n = 1'b1;
        end else if (ones == 4'd0) begin
          ones_n = 4'd9;
          tens_n = tens - 4'd1;
        end else begin
          ones_n = ones - 4'd1;
        end
      end else begin
        if (at_max) begin
          tens_n  = 4'd0;
          ones_n  = 4'd0;
          carry_n = 1'b1;
        end else if (ones == 4'd9) begin
          ones_n = 4'd0;
          tens_n = tens + 4'd1;
        end else begin
          ones_n = ones + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens     <= 4'd0;
      ones     <= 4'd0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tens     <= tens_n;
      ones     <= ones_n;
      carry    <= carry_n;
      load_err <= load_err_n;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: mod-60, mod-24 and a cascaded 60/60 pair.
// Down-count checks run when BCD_COUNTER_DOWN_COUNT_EN is defined.
module tb_bcd_mod_counter;

  typedef struct {
    int         seq;
    int         id;
    logic [3:0] t;
    logic [3:0] o;
    logic       c;
    logic       e;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic [3:0] rst_v;
  logic [3:0] clr_v;
  logic [3:0] load_v;
  logic [3:0] tick_v;
  logic [3:0] lt_v [4];
  logic [3:0] lo_v [4];
  logic [3:0] tens_o [4];
  logic [3:0] ones_o [4];
  logic [3:0] carry_o;
  logic [3:0] lerr_o;
  logic [3:0] tc_o;
`ifdef BCD_COUNTER_DOWN_COUNT_EN
  logic       dir = 1'b0;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_seq = 0;

  always #5 clk = ~clk;

  // id 0: mod 60, id 1: mod 24, id 2/3: cascaded seconds/minutes
  bcd_mod_counter #(.MODULO(60)) u60 (
    .clk(clk), .rst(rst_v[0]), .tick(tick_v[0]), .clr(clr_v[0]), .load(load_v[0]),
    .load_tens(lt_v[0]), .load_ones(lo_v[0]),
`ifdef BCD_COUNTER_DOWN_COUNT_EN
    .dir(dir),
`endif
    .tens(tens_o[0]), .ones(ones_o[0]), .term_cnt(tc_o[0]), .carry(carry_o[0]), .load_err(lerr_o[0]));

  bcd_mod_counter #(.MODULO(24)) u24 (
    .clk(clk), .rst(rst_v[1]), .tick(tick_v[1]), .clr(clr_v[1]), .load(load_v[1]),
    .load_tens(lt_v[1]), .load_ones(lo_v[1]),
`ifdef BCD_COUNTER_DOWN_COUNT_EN
    .dir(1'b0),
`endif
    .tens(tens_o[1]), .ones(ones_o[1]), .term_cnt(tc_o[1]), .carry(carry_o[1]), .load_err(lerr_o[1]));

  bcd_mod_counter #(.MODULO(60)) u_c0 (
    .clk(clk), .rst(rst_v[2]), .tick(tick_v[2]), .clr(clr_v[2]), .load(load_v[2]),
    .load_tens(lt_v[2]), .load_ones(lo_v[2]),
`ifdef BCD_COUNTER_DOWN_COUNT_EN
    .dir(1'b0),
`endif
    .tens(tens_o[2]), .ones(ones_o[2]), .term_cnt(tc_o[2]), .carry(carry_o[2]), .load_err(lerr_o[2]));

  bcd_mod_counter #(.MODULO(60)) u_c1 (
    .clk(clk), .rst(rst_v[3]), .tick(tick_v[2] & tc_o[2]), .clr(clr_v[3]), .load(load_v[3]),
    .load_tens(lt_v[3]), .load_ones(lo_v[3]),
`ifdef BCD_COUNTER_DOWN_COUNT_EN
    .dir(1'b0),
`endif
    .tens(tens_o[3]), .ones(ones_o[3]), .term_cnt(tc_o[3]), .carry(carry_o[3]), .load_err(lerr_o[3]));

  task automatic idle();
    rst_v  = '0;
    clr_v  = '0;
    load_v = '0;
    tick_v = '0;
    for (int k = 0; k < 4; k++) begin
      lt_v[k] = '0;
      lo_v[k] = '0;
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic ld(input int id, input int t, input int o);
    load_v[id] = 1'b1;
    lt_v[id]   = 4'(t);
    lo_v[id]   = 4'(o);
  endtask

  task automatic ex(input int id, input int v, input bit c, input bit e, input bit tc);
    exp_t x;
    n_seq++;
    x.seq = n_seq;
    x.id  = id;
    x.t   = 4'(v / 10);
    x.o   = 4'(v % 10);
    x.c   = c;
    x.e   = e;
    x.tc  = tc;
    sb.push_back(x);
  endtask

  task automatic ex_raw(input int id, input int t, input int o, input bit c, input bit e, input bit tc);
    exp_t x;
    n_seq++;
    x.seq = n_seq;
    x.id  = id;
    x.t   = 4'(t);
    x.o   = 4'(o);
    x.c   = c;
    x.e   = e;
    x.tc  = tc;
    sb.push_back(x);
  endtask

  // Monitor: outputs are checked 1 time unit after each active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        n_cmp++;
        if (tens_o[x.id] !== x.t || ones_o[x.id] !== x.o || carry_o[x.id] !== x.c ||
            lerr_o[x.id] !== x.e || tc_o[x.id] !== x.tc) begin
          n_bad++;
          $display("FAIL chk%0d dut%0d: got t=%0d o=%0d carry=%0b lerr=%0b tc=%0b, want t=%0d o=%0d carry=%0b lerr=%0b tc=%0b",
                   x.seq, x.id, tens_o[x.id], ones_o[x.id], carry_o[x.id], lerr_o[x.id], tc_o[x.id],
                   x.t, x.o, x.c, x.e, x.tc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // Reset for two cycles on every instance
    rst_v = 4'hF;
    @(posedge clk);
    for (int k = 0; k < 4; k++) ex(k, 0, 0, 0, 0);
    nxt();
    rst_v = 4'hF;
    @(posedge clk);
    for (int k = 0; k < 4; k++) ex(k, 0, 0, 0, 0);

    // Mod-60 full up sequence and wrap
    for (int i = 1; i <= 59; i++) begin
      nxt(); tick_v[0] = 1'b1;
      @(posedge clk); ex(0, i, 0, 0, i == 59);
    end
    nxt(); tick_v[0] = 1'b1;
    @(posedge clk); ex(0, 0, 1, 0, 0);
    nxt();
    @(posedge clk); ex(0, 0, 0, 0, 0);

    // Mod-24: load 23, wrap, rejected loads
    nxt(); ld(1, 2, 3);
    @(posedge clk); ex(1, 23, 0, 0, 1);
    nxt(); tick_v[1] = 1'b1;
    @(posedge clk); ex(1, 0, 1, 0, 0);
    nxt(); ld(1, 2, 4);
    @(posedge clk); ex(1, 0, 0, 1, 0);
    nxt();
    @(posedge clk); ex(1, 0, 0, 0, 0);
    nxt(); ld(1, 1, 9);
    @(posedge clk); ex(1, 19, 0, 0, 0);
    nxt(); ld(1, 0, 12); tick_v[1] = 1'b1;
    @(posedge clk); ex(1, 19, 0, 1, 0);
    nxt();
    @(posedge clk); ex(1, 19, 0, 0, 0);
    nxt(); tick_v[1] = 1'b1;
    @(posedge clk); ex(1, 20, 0, 0, 0);

    // Mod-60: clr and load take priority over tick
    nxt(); ld(0, 3, 7);
    @(posedge clk); ex(0, 37, 0, 0, 0);
    nxt(); clr_v[0] = 1'b1; tick_v[0] = 1'b1;
    @(posedge clk); ex(0, 0, 0, 0, 0);
    nxt(); ld(0, 1, 5); tick_v[0] = 1'b1;
    @(posedge clk); ex(0, 15, 0, 0, 0);
    nxt(); ld(0, 2, 0); clr_v[0] = 1'b1;
    @(posedge clk); ex(0, 0, 0, 0, 0);
    nxt(); ld(0, 6, 0);
    @(posedge clk); ex(0, 0, 0, 1, 0);

    // Cascade 59:59 -> 00:00 with both carries in the same cycle
    nxt(); ld(2, 5, 9); ld(3, 5, 9);
    @(posedge clk); ex(2, 59, 0, 0, 1); ex(3, 59, 0, 0, 1);
    nxt(); tick_v[2] = 1'b1;
    @(posedge clk); ex(2, 0, 1, 0, 0); ex(3, 0, 1, 0, 0);
    nxt(); tick_v[2] = 1'b1;
    @(posedge clk); ex(2, 1, 0, 0, 0); ex(3, 0, 0, 0, 0);
    nxt(); ld(2, 5, 9);
    @(posedge clk); ex(2, 59, 0, 0, 1); ex(3, 0, 0, 0, 0);
    nxt(); tick_v[2] = 1'b1;
    @(posedge clk); ex(2, 0, 1, 0, 0); ex(3, 1, 0, 0, 0);

    // Reset mid-count dominates tick and load
    nxt(); ld(0, 4, 5);
    @(posedge clk); ex(0, 45, 0, 0, 0);
    nxt(); rst_v[0] = 1'b1; tick_v[0] = 1'b1;
    @(posedge clk); ex(0, 0, 0, 0, 0);
    nxt(); rst_v[0] = 1'b1; tick_v[0] = 1'b1;
    @(posedge clk); ex(0, 0, 0, 0, 0);
    nxt(); rst_v[0] = 1'b1; ld(0, 1, 2);
    @(posedge clk); ex(0, 0, 0, 0, 0);
    nxt(); tick_v[0] = 1'b1;
    @(posedge clk); ex_raw(0, 0, 1, 0, 0, 0);

`ifdef BCD_COUNTER_DOWN_COUNT_EN
    // Down count: borrow at 00, digit borrow at 10, direction switch
    nxt(); dir = 1'b1; clr_v[0] = 1'b1;
    @(posedge clk); ex(0, 0, 0, 0, 1);
    nxt(); tick_v[0] = 1'b1;
    @(posedge clk); ex(0, 59, 1, 0, 0);
    nxt(); ld(0, 1, 0);
    @(posedge clk); ex(0, 10, 0, 0, 0);
    nxt(); tick_v[0] = 1'b1;
    @(posedge clk); ex(0, 9, 0, 0, 0);
    nxt(); dir = 1'b0; tick_v[0] = 1'b1;
    @(posedge clk); ex(0, 10, 0, 0, 0);
    nxt(); ld(0, 5, 9);
    @(posedge clk); ex(0, 59, 0, 0, 1);
`endif

    nxt();
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
